// File: rtl/seq_multiplier_if.sv
// ============================================================================
// Module : seq_multiplier_if
// Brief  : Request/response bundle for the iterative shift-add multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module : seq_multiplier
// Brief  : Iterative shift-add multiplier, one step per clock, signed/unsigned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seq_multiplier_if.slave     bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;
    logic [CW-1:0]          count;
    logic                   neg;
    logic                   done_q;
    logic [2*WIDTH-1:0]     product_q;

    logic                   busy;
    logic                   load;
    logic                   complete;
    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;
    logic [WIDTH-1:0]       addend;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       step_hi;
    logic [WIDTH-1:0]       step_lo;
    logic [2*WIDTH-1:0]     full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        load       = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST_STEP) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Magnitudes fit in WIDTH bits unsigned, including |-2^(WIDTH-1)|.
    assign abs_a = (bus.signed_mode && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand
                                                                  : bus.multiplicand;
    assign abs_b = (bus.signed_mode && bus.multiplier[WIDTH-1])   ? -bus.multiplier
                                                                  : bus.multiplier;

    // Carry is always zero between steps, so it lives only in the sum's MSB.
    assign addend  = lo[0] ? mcand : '0;
    assign sum     = {1'b0, hi} + {1'b0, addend};
    assign step_hi = sum[WIDTH:1];
    assign step_lo = {sum[0], lo[WIDTH-1:1]};
    assign full    = {step_hi, step_lo};

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            neg       <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= complete;
            if (load) begin
                neg   <= bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                mcand <= abs_a;
                hi    <= '0;
                lo    <= abs_b;
                count <= '0;
            end else if (busy) begin
                hi    <= step_hi;
                lo    <= step_lo;
                count <= complete ? '0 : count + 1'b1;
                if (complete) begin
                    product_q <= neg ? -full : full;
                end
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module : tb_seq_multiplier
// Brief  : Randomised self-checking bench for 32-bit and 8-bit multipliers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [63:0] last32;

    seq_multiplier_if #(.WIDTH(32)) bus32 ();
    seq_multiplier_if #(.WIDTH(8))  bus8 ();

    seq_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b, input logic sm);
        logic signed [63:0] sa, sb;
        sa = sm ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sm ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction

    function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int sa, sb;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                            output logic [63:0] prod, output int lat, output int busy_cnt,
                            output bit overlap);
        bus32.start = 1'b1; bus32.multiplicand = a; bus32.multiplier = b; bus32.signed_mode = sm;
        @(negedge clk);
        bus32.start = 1'b0;
        bus32.multiplicand = $urandom; bus32.multiplier = $urandom; bus32.signed_mode = 1'($urandom);
        lat = 1; busy_cnt = 0; overlap = 0;
        while (!bus32.done && lat < 60) begin
            if (bus32.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (bus32.done && bus32.busy) overlap = 1;
        prod = bus32.product;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                           output logic [15:0] prod, output int lat, output bit overlap);
        bus8.start = 1'b1; bus8.multiplicand = a; bus8.multiplier = b; bus8.signed_mode = sm;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.multiplicand = 8'($urandom); bus8.multiplier = 8'($urandom); bus8.signed_mode = 1'($urandom);
        lat = 1; overlap = 0;
        while (!bus8.done && lat < 30) begin
            if (bus8.busy && bus8.done) overlap = 1;
            @(negedge clk);
            lat++;
        end
        if (bus8.done && bus8.busy) overlap = 1;
        prod = bus8.product;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus32.start = 1'b1; bus32.multiplicand = $urandom; bus32.multiplier = $urandom; bus32.signed_mode = 1'($urandom);
        bus8.start = 1'b1;  bus8.multiplicand = 8'($urandom); bus8.multiplier = 8'($urandom); bus8.signed_mode = 1'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if (bus32.product !== 64'd0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            failures++;
            $display("FAIL reset32: product=%h busy=%b done=%b, required 0/0/0", bus32.product, bus32.busy, bus32.done);
        end
        checks++;
        if (bus8.product !== 16'd0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            failures++;
            $display("FAIL reset8: product=%h busy=%b done=%b, required 0/0/0", bus8.product, bus8.busy, bus8.done);
        end
        rst = 1'b1; bus32.start = 1'b0; bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus32.product !== 64'd0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release32: product=%h busy=%b done=%b, required 0/0/0", bus32.product, bus32.busy, bus32.done);
        end
        checks++;
        if (bus8.product !== 16'd0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release8: product=%h busy=%b done=%b, required 0/0/0", bus8.product, bus8.busy, bus8.done);
        end
    endtask

    task automatic test_unsigned_max;
        logic [63:0] p; int lat, bc; bit ov;
        run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, bc, ov);
        checks++;
        if (p !== 64'hFFFF_FFFE_0000_0001) begin
            failures++; $display("FAIL umax_product: got %h required %h", p, 64'hFFFF_FFFE_0000_0001);
        end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL umax_latency: got %0d required 33", lat); end
        checks++;
        if (bc !== 32) begin failures++; $display("FAIL umax_busy_cycles: got %0d required 32", bc); end
        checks++;
        if (ov) begin failures++; $display("FAIL umax_done_busy_overlap: got 1 required 0"); end
        last32 = 64'hFFFF_FFFE_0000_0001;
    endtask

    task automatic test_signed;
        logic [63:0] p; int lat, bc; bit ov;
        run_op32(32'hFFFF_FFFD, 32'd7, 1'b1, p, lat, bc, ov);
        checks++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            failures++; $display("FAIL signed_m3x7: got %h required %h", p, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL signed_m3x7_latency: got %0d required 33", lat); end
        run_op32(32'h8000_0000, 32'h8000_0000, 1'b1, p, lat, bc, ov);
        checks++;
        if (p !== 64'h4000_0000_0000_0000) begin
            failures++; $display("FAIL signed_minxmin: got %h required %h", p, 64'h4000_0000_0000_0000);
        end
        last32 = 64'h4000_0000_0000_0000;
    endtask

    task automatic test_back_to_back;
        int lat;
        bus32.start = 1'b1; bus32.multiplicand = 32'd6; bus32.multiplier = 32'd7; bus32.signed_mode = 1'b0;
        @(negedge clk);
        bus32.start = 1'b0;
        lat = 1;
        while (lat < 5) begin @(negedge clk); lat++; end
        bus32.start = 1'b1; bus32.multiplicand = 32'd2; bus32.multiplier = 32'd2;
        @(negedge clk); lat++;
        bus32.start = 1'b0;
        checks++;
        if (bus32.product !== last32) begin
            failures++; $display("FAIL b2b_hold_midcalc: got %h required %h", bus32.product, last32);
        end
        while (!bus32.done && lat < 60) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL b2b_first_latency: got %0d required 33", lat); end
        checks++;
        if (bus32.product !== 64'd42) begin
            failures++; $display("FAIL b2b_first_product: got %h required %h", bus32.product, 64'd42);
        end
        bus32.start = 1'b1; bus32.multiplicand = 32'd5; bus32.multiplier = 32'd5;
        @(negedge clk);
        bus32.start = 1'b0;
        lat = 1;
        checks++;
        if (bus32.done !== 1'b0 || bus32.busy !== 1'b1 || bus32.product !== 64'd42) begin
            failures++;
            $display("FAIL b2b_after_done: done=%b busy=%b product=%h required 0/1/%h", bus32.done, bus32.busy, bus32.product, 64'd42);
        end
        while (!bus32.done && lat < 60) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 33 || bus32.product !== 64'd25) begin
            failures++; $display("FAIL b2b_second: latency=%0d product=%h required 33/%h", lat, bus32.product, 64'd25);
        end
        last32 = 64'd25;
    endtask

    task automatic test_reset_mid;
        logic [63:0] p; int lat, bc; bit ov; bit saw_done;
        saw_done = 0;
        bus32.start = 1'b1; bus32.multiplicand = 32'h1234; bus32.multiplier = 32'h10; bus32.signed_mode = 1'b0;
        @(negedge clk);
        bus32.start = 1'b0;
        lat = 1;
        while (lat < 10) begin if (bus32.done) saw_done = 1; @(negedge clk); lat++; end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) begin if (bus32.done) saw_done = 1; @(negedge clk); end
        checks++;
        if (saw_done || bus32.product !== 64'd0 || bus32.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: done_seen=%b product=%h busy=%b required 0/0/0", saw_done, bus32.product, bus32.busy);
        end
        run_op32(32'h1234, 32'h10, 1'b0, p, lat, bc, ov);
        checks++;
        if (p !== 64'h12340 || lat !== 33) begin
            failures++; $display("FAIL reset_mid_restart: product=%h latency=%0d required %h/33", p, lat, 64'h12340);
        end
        last32 = 64'h12340;
    endtask

    task automatic test_random32;
        logic [63:0] p, e; logic [31:0] a, b; logic sm; int lat, bc; bit ov;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom; sm = 1'($urandom);
            if (i % 6 == 0) a = 32'h8000_0000;
            if (i % 6 == 1) b = 32'h0;
            e = ref_mul32(a, b, sm);
            run_op32(a, b, sm, p, lat, bc, ov);
            checks++;
            if (p !== e || lat !== 33 || bc !== 32 || ov) begin
                failures++;
                $display("FAIL rand32: a=%h b=%h sm=%b product=%h lat=%0d busy=%0d ov=%b required %h/33/32/0",
                         a, b, sm, p, lat, bc, ov, e);
            end
        end
    endtask

    task automatic test_width8;
        logic [15:0] p, e; logic [7:0] a, b; logic sm; int lat; bit ov;
        logic [7:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h81};
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    a = corners[i]; b = corners[j]; sm = 1'(m);
                    e = ref_mul8(a, b, sm);
                    run_op8(a, b, sm, p, lat, ov);
                    checks++;
                    if (p !== e || lat !== 9 || ov) begin
                        failures++;
                        $display("FAIL w8_corner: a=%h b=%h sm=%b product=%h lat=%0d ov=%b required %h/9/0", a, b, sm, p, lat, ov, e);
                    end
                end
            end
        end
        for (int i = 0; i < 1500; i++) begin
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            e = ref_mul8(a, b, sm);
            run_op8(a, b, sm, p, lat, ov);
            checks++;
            if (p !== e || lat !== 9 || ov) begin
                failures++;
                $display("FAIL w8_rand: a=%h b=%h sm=%b product=%h lat=%0d ov=%b required %h/9/0", a, b, sm, p, lat, ov, e);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; last32 = '0;
        rst = 1'b0;
        bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.multiplicand = '0; bus32.multiplier = '0;
        bus8.start = 1'b0;  bus8.signed_mode = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;
        @(negedge clk);
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_random32();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
